// File: rtl/pixel_readout_capture.sv
// Samples the pixel bus pairs during read12/read34 and streams each frame as four bytes.
// A frame half is dropped (overflow) unless two FIFO slots are free at sample time.
module pixel_readout_capture #(
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_DLY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        read12,
    input  logic                        read34,
    input  logic [7:0]                  pixData1,
    input  logic [7:0]                  pixData2,
    input  logic [7:0]                  pixData3,
    input  logic [7:0]                  pixData4,
    output logic [7:0]                  dout,
    output logic                        dout_valid,
    output logic                        dout_last,
    input  logic                        dout_ready,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fill_level,
    output logic                        overflow,
    output logic                        seq_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DLY = 4'(SAMPLE_DLY);
    localparam logic [AW:0] FILL_MAX = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0] FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0] FILL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE, R12, PUSH12A, PUSH12B, W12LOW,
        WAIT34, R34, PUSH34A, PUSH34B, W34LOW
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt, cnt_inc;
    logic          abort, abort_nxt;
    logic [7:0]    stg_lo, stg_hi;
    logic          start12, start34, sample12, sample34;
    logic          cap12, cap34;
    logic          push, push_last, pop;
    logic [7:0]    push_byte;
    logic          set_ovf, set_seq;
    logic          space_ok;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign cnt_inc    = cnt + 4'd1;
    assign space_ok   = fill_level <= FILL_MAX;
    assign dout_valid = fill_level != '0;
    assign pop        = dout_valid & dout_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_nxt = abort;
        start12   = 1'b0;
        start34   = 1'b0;
        sample12  = 1'b0;
        sample34  = 1'b0;
        cap12     = 1'b0;
        cap34     = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        push_byte = stg_lo;
        set_ovf   = 1'b0;
        set_seq   = 1'b0;

        case (state)
            IDLE: begin
                if (read34) set_seq = 1'b1;
                else if (read12) start12 = 1'b1;
            end
            R12: begin
                if (!read12 || read34) begin
                    set_seq   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt  = cnt_inc;
                    sample12 = (cnt_inc == DLY);
                end
            end
            PUSH12A: begin
                push      = 1'b1;
                push_byte = stg_lo;
                state_nxt = PUSH12B;
            end
            PUSH12B: begin
                push      = 1'b1;
                push_byte = stg_hi;
                state_nxt = W12LOW;
            end
            W12LOW: begin
                // An aborted first half must not be followed by a 34 phase.
                if (!read12) state_nxt = abort ? IDLE : WAIT34;
            end
            WAIT34: begin
                if (read12) begin
                    set_seq = 1'b1;
                    start12 = 1'b1;
                end else if (read34) begin
                    start34 = 1'b1;
                end
            end
            R34: begin
                if (!read34 || read12) begin
                    set_seq   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt  = cnt_inc;
                    sample34 = (cnt_inc == DLY);
                end
            end
            PUSH34A: begin
                push      = 1'b1;
                push_byte = stg_lo;
                state_nxt = PUSH34B;
            end
            PUSH34B: begin
                push      = 1'b1;
                push_byte = stg_hi;
                push_last = 1'b1;
                state_nxt = W34LOW;
            end
            W34LOW: begin
                if (!read34) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // The first high edge counts as 1, so a delay of 1 samples on entry.
        if (start12) begin
            cnt_nxt   = 4'd1;
            abort_nxt = 1'b0;
            state_nxt = R12;
            sample12  = (DLY == 4'd1);
        end
        if (start34) begin
            cnt_nxt   = 4'd1;
            state_nxt = R34;
            sample34  = (DLY == 4'd1);
        end

        if (sample12) begin
            cap12 = 1'b1;
            if (space_ok) begin
                state_nxt = PUSH12A;
            end else begin
                set_ovf   = 1'b1;
                abort_nxt = 1'b1;
                state_nxt = W12LOW;
            end
        end
        if (sample34) begin
            cap34 = 1'b1;
            if (space_ok) begin
                state_nxt = PUSH34A;
            end else begin
                set_ovf   = 1'b1;
                state_nxt = W34LOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            abort      <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            seq_err    <= 1'b0;
            stg_lo     <= '0;
            stg_hi     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            abort      <= abort_nxt;
            frame_done <= (state == PUSH34B);
            overflow   <= overflow | set_ovf;
            seq_err    <= seq_err | set_seq;
            if (cap12) begin
                stg_lo <= pixData1;
                stg_hi <= pixData2;
            end else if (cap34) begin
                stg_lo <= pixData3;
                stg_hi <= pixData4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_last, push_byte};
    end

    // dout/dout_last are a registered copy of the head so they hold while empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            dout       <= '0;
            dout_last  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            if (push && (fill_level == '0 || (pop && fill_level == FILL_ONE))) begin
                {dout_last, dout} <= {push_last, push_byte};
            end else if (pop && fill_level > FILL_ONE) begin
                {dout_last, dout} <= mem[rd_ptr + 1'b1];
            end
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        push |-> (fill_level != FILL_FULL));

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Phase-level stimulus with a queue-based reference model; the output stream is checked on every handshake.
module tb_pixel_readout_capture;
    localparam int DEPTH = 8;
    localparam int DLY   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       read12 = 1'b0, read34 = 1'b0;
    logic [7:0] pixData1 = '0, pixData2 = '0, pixData3 = '0, pixData4 = '0;
    logic [7:0] dout;
    logic       dout_valid, dout_last, frame_done, overflow, seq_err;
    logic       dout_ready = 1'b0;
    logic [$clog2(DEPTH):0] fill_level;

    pixel_readout_capture #(.FIFO_DEPTH(DEPTH), .SAMPLE_DLY(DLY)) dut (
        .clk(clk), .reset(reset), .read12(read12), .read34(read34),
        .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .frame_done(frame_done), .fill_level(fill_level), .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] b;
    } ent_t;

    ent_t       exp_q[$];
    logic [8:0] got_log[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int pushed = 0, popped = 0;
    int frames_exp = 0, frames_seen = 0;
    bit m_ovf = 0, m_seq = 0;
    int m_mode = 0;   // 0: next legal phase is read12, 1: read34 expected
    int rdy_mode = 0; // 0: never ready, 1: always ready, 2: random
    int phase_t0 = 0, first_valid_cyc = -1, last_fd_cyc = -1, max_fill = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: every accepted byte must be the next one the model predicts.
    always @(negedge clk) begin
        if (reset) begin
            check("fill_bound", 32'(fill_level <= DEPTH), 1);
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (frame_done) begin
                frames_seen++;
                last_fd_cyc = cyc;
            end
            if (dout_valid && dout_ready) begin
                popped++;
                got_log.push_back({dout_last, dout});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected got=%0h expected=none at cycle %0d", dout, cyc);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    check("dout", 32'(dout), 32'(e.b));
                    check("dout_last", 32'(dout_last), 32'(e.last));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        exp_q.delete();
        pushed = 0; popped = 0;
        frames_exp = 0; frames_seen = 0;
        m_ovf = 0; m_seq = 0; m_mode = 0;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0; read12 = 1'b0; read34 = 1'b0; rdy_mode = 0;
        step();
        step();
        reset = 1'b1;
        model_clear();
    endtask

    // kind 0: read12 phase, 1: read34 phase, 2: both lines high.
    task automatic drive_phase(input int kind, input int len, input int gap,
                               input logic [7:0] a, input logic [7:0] b);
        int occ;
        bit will_cap;
        will_cap = (kind != 2) && (len >= DLY) && !(kind == 1 && m_mode == 0);
        if (kind == 2 || (kind == 1 && m_mode == 0) || (kind == 0 && m_mode == 1) || len < DLY)
            m_seq = 1'b1;
        if (!will_cap) m_mode = 0;
        for (int i = 1; i <= len; i++) begin
            step();
            if (i == 1) phase_t0 = cyc + 1;
            read12   = (kind != 1);
            read34   = (kind != 0);
            pixData1 = (kind == 0) ? a : 8'($urandom);
            pixData2 = (kind == 0) ? b : 8'($urandom);
            pixData3 = (kind == 1) ? a : 8'($urandom);
            pixData4 = (kind == 1) ? b : 8'($urandom);
            if (will_cap && i == DLY) begin
                occ = pushed - popped;
                if (occ <= DEPTH - 2) begin
                    exp_q.push_back({1'b0, a});
                    exp_q.push_back({(kind == 1), b});
                    pushed += 2;
                    if (kind == 1) begin
                        frames_exp++;
                        m_mode = 0;
                    end else begin
                        m_mode = 1;
                    end
                end else begin
                    m_ovf  = 1'b1;
                    m_mode = 0;
                end
            end
        end
        for (int i = 0; i < gap; i++) begin
            step();
            read12 = 1'b0; read34 = 1'b0;
            pixData1 = 8'($urandom); pixData2 = 8'($urandom);
            pixData3 = 8'($urandom); pixData4 = 8'($urandom);
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        drive_phase(0, 4, 3, b0, b1);
        drive_phase(1, 4, 3, b2, b3);
    endtask

    task automatic quiesce();
        rdy_mode = 1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        repeat (3) step();
        check("drain", 32'(exp_q.size()), 0);
        check("fill_model", 32'(fill_level), 32'(pushed - popped));
        check("overflow_model", 32'(overflow), 32'(m_ovf));
        check("seq_err_model", 32'(seq_err), 32'(m_seq));
        check("frames_model", 32'(frames_seen), 32'(frames_exp));
    endtask

    int t12, t34, kind, len;
    logic [8:0] want [8];

    initial begin
        do_reset();
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_last", 32'(dout_last), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_fill", 32'(fill_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_seq_err", 32'(seq_err), 0);

        // Normal frame with latency pins.
        rdy_mode = 1;
        got_log.delete();
        first_valid_cyc = -1;
        drive_phase(0, 4, 3, 8'h11, 8'h22);
        t12 = phase_t0;
        drive_phase(1, 4, 3, 8'h33, 8'h44);
        t34 = phase_t0;
        quiesce();
        check("normal_count", 32'(got_log.size()), 4);
        want[0] = 9'h011; want[1] = 9'h022; want[2] = 9'h033; want[3] = 9'h144;
        for (int i = 0; i < 4 && i < got_log.size(); i++) check("normal_byte", 32'(got_log[i]), 32'(want[i]));
        check("valid_latency", 32'(first_valid_cyc), 32'(t12 + DLY));
        check("frame_done_time", 32'(last_fd_cyc), 32'(t34 + DLY + 1));
        check("frame_done_once", 32'(frames_seen), 1);
        check("normal_fill_end", 32'(fill_level), 0);

        // Back-pressure until full, third frame dropped.
        rdy_mode = 0;
        frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        check("full_fill", 32'(fill_level), 8);
        check("full_overflow", 32'(overflow), 1);
        check("full_seq_err", 32'(seq_err), 1);
        got_log.delete();
        quiesce();
        check("full_count", 32'(got_log.size()), 8);
        want[0] = 9'h0A0; want[1] = 9'h0A1; want[2] = 9'h0A2; want[3] = 9'h1A3;
        want[4] = 9'h0B0; want[5] = 9'h0B1; want[6] = 9'h0B2; want[7] = 9'h1B3;
        for (int i = 0; i < 8 && i < got_log.size(); i++) check("full_byte", 32'(got_log[i]), 32'(want[i]));

        // Sequence errors.
        do_reset();
        drive_phase(1, 1, 3, 8'h01, 8'h02);
        check("r34_idle_seq", 32'(seq_err), 1);
        check("r34_idle_fill", 32'(fill_level), 0);
        do_reset();
        drive_phase(2, 3, 3, 8'h03, 8'h04);
        check("both_seq", 32'(seq_err), 1);
        check("both_fill", 32'(fill_level), 0);
        do_reset();
        drive_phase(0, 1, 3, 8'h05, 8'h06);
        check("short_seq", 32'(seq_err), 1);
        check("short_fill", 32'(fill_level), 0);
        got_log.delete();
        drive_phase(0, 3, 3, 8'h51, 8'h52);
        drive_phase(1, 3, 3, 8'h53, 8'h54);
        quiesce();
        check("short_next_count", 32'(got_log.size()), 4);

        // Reset during PUSH12B; seq_err is still set from above.
        rdy_mode = 0;
        step(); read12 = 1'b1; pixData1 = 8'h5A; pixData2 = 8'hA5;
        step();
        step();
        step();
        check("mid_fill_before", 32'(fill_level), 1);
        reset = 1'b0;
        step();
        check("mid_dout", 32'(dout), 0);
        check("mid_valid", 32'(dout_valid), 0);
        check("mid_last", 32'(dout_last), 0);
        check("mid_frame_done", 32'(frame_done), 0);
        check("mid_fill", 32'(fill_level), 0);
        check("mid_overflow", 32'(overflow), 0);
        check("mid_seq_err", 32'(seq_err), 0);
        reset = 1'b1; read12 = 1'b0;
        model_clear();
        got_log.delete();
        drive_phase(0, 3, 3, 8'h61, 8'h62);
        drive_phase(1, 3, 3, 8'h63, 8'h64);
        quiesce();
        check("mid_after_count", 32'(got_log.size()), 4);
        want[0] = 9'h061; want[1] = 9'h062; want[2] = 9'h063; want[3] = 9'h164;
        for (int i = 0; i < 4 && i < got_log.size(); i++) check("mid_after_byte", 32'(got_log[i]), 32'(want[i]));

        // Continuous drain with pointer wrap.
        do_reset();
        rdy_mode = 1;
        max_fill = 0;
        got_log.delete();
        for (int f = 0; f < 10; f++)
            frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        quiesce();
        check("wrap_count", 32'(got_log.size()), 40);
        check("wrap_max_fill", 32'(max_fill <= 2), 1);
        for (int i = 0; i < got_log.size(); i++) check("wrap_last", 32'(got_log[i][8]), 32'((i % 4) == 3));

        // Randomized phases and random back-pressure.
        do_reset();
        rdy_mode = 2;
        for (int p = 0; p < 150; p++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) kind = 2;
            else if (r == 1) kind = (m_mode == 0) ? 1 : 0;
            else kind = (m_mode == 0) ? 0 : 1;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DLY - 1) : $urandom_range(DLY, DLY + 3);
            drive_phase(kind, len, $urandom_range(3, 5), 8'($urandom), 8'($urandom));
            if (p % 25 == 24) begin
                quiesce();
                rdy_mode = 2;
            end
        end
        quiesce();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
